// File: rtl/note_scheduler.sv
// note_scheduler: chart-driven note spawner, per-frame mover and key-hit judge.
// Walks the chart ROM, keeps a fixed pool of falling note slots, and keeps
// score / combo / miss counters for the renderer and HUD.
`timescale 1ns/1ps
module note_scheduler #(
    parameter int NUM_SLOTS  = 8,
    parameter int SPEED      = 4,
    parameter int RECEPTOR_Y = 64,
    parameter int WINDOW     = 12,
    parameter int ADDR_W     = 8
) (
    input  logic                    Clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    frame_clk,
    input  logic [7:0]              keycode,
    input  logic                    press,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [18:0]             rom_data,
    output logic [NUM_SLOTS-1:0]    note_valid,
    output logic [2*NUM_SLOTS-1:0]  note_lane,
    output logic [10*NUM_SLOTS-1:0] note_y,
    output logic [15:0]             score,
    output logic [7:0]              combo,
    output logic [7:0]              misses,
    output logic                    playing
);

    localparam int         IDX_W   = $clog2(NUM_SLOTS);
    localparam int         HIT_LO  = RECEPTOR_Y - WINDOW;
    localparam int         HIT_HI  = RECEPTOR_Y + WINDOW;
    localparam int         EXIT_Y  = RECEPTOR_Y - WINDOW + SPEED;
    localparam logic [9:0] SPAWN_Y = 10'd479;
    localparam logic [9:0] STEP    = 10'(SPEED);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CHECK, S_WAIT, S_MOVE, S_DRAIN} state_t;

    state_t                    state_q, state_d;
    logic                      fetch_cnt_q, fetch_cnt_d;
    logic                      chart_done_q, chart_done_d;
    logic [15:0]               frame_q, frame_d;
    logic [ADDR_W-1:0]         rom_addr_q, rom_addr_d;
    logic                      fsync1_q, fsync1_d, fsync2_q, fsync2_d, fsync3_q, fsync3_d;
    logic                      press1_q, press1_d, press2_q, press2_d;
    logic                      tick_pend_q, tick_pend_d;
    logic                      hit_pend_q, hit_pend_d;
    logic [1:0]                hit_lane_q, hit_lane_d;
    logic [NUM_SLOTS-1:0]      valid_q, valid_d;
    logic [NUM_SLOTS-1:0][1:0] lane_q, lane_d;
    logic [NUM_SLOTS-1:0][9:0] y_q, y_d;
    logic [15:0]               score_q, score_d;
    logic [7:0]                combo_q, combo_d, misses_q, misses_d;

    logic             tick, press_rise, key_ok, tick_taken;
    logic [1:0]       key_lane;
    logic             free_found, hit_found;
    logic [IDX_W-1:0] free_idx, hit_idx;
    logic [9:0]       best_y;

    function automatic logic [7:0] sat8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign tick       = fsync2_q & ~fsync3_q;
    assign press_rise = press1_q & ~press2_q;

    // Arrow-key make codes to lane number
    always_comb begin
        key_ok   = 1'b1;
        key_lane = 2'd0;
        case (keycode)
            8'h6B:   key_lane = 2'd0;
            8'h72:   key_lane = 2'd1;
            8'h75:   key_lane = 2'd2;
            8'h74:   key_lane = 2'd3;
            default: key_ok = 1'b0;
        endcase
    end

    // Lowest-index free slot for spawning
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Lowest in-window note of the pending lane; strict compare keeps lowest index on ties
    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        best_y    = '1;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (valid_q[i] && lane_q[i] == hit_lane_q &&
                int'(y_q[i]) >= HIT_LO && int'(y_q[i]) <= HIT_HI &&
                (!hit_found || y_q[i] < best_y)) begin
                hit_found = 1'b1;
                hit_idx   = IDX_W'(i);
                best_y    = y_q[i];
            end
        end
    end

    // Next-state, slot pool and scoring update
    always_comb begin
        state_d      = state_q;
        fetch_cnt_d  = 1'b0;
        chart_done_d = chart_done_q;
        frame_d      = frame_q;
        rom_addr_d   = rom_addr_q;
        fsync1_d     = frame_clk;
        fsync2_d     = fsync1_q;
        fsync3_d     = fsync2_q;
        press1_d     = press;
        press2_d     = press1_q;
        tick_pend_d  = tick_pend_q;
        hit_pend_d   = hit_pend_q;
        hit_lane_d   = hit_lane_q;
        valid_d      = valid_q;
        lane_d       = lane_q;
        y_d          = y_q;
        score_d      = score_q;
        combo_d      = combo_q;
        misses_d     = misses_q;
        tick_taken   = 1'b0;

        case (state_q)
            S_IDLE: ;
            S_FETCH: begin
                fetch_cnt_d = 1'b1;
                if (fetch_cnt_q) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (rom_data[18]) begin
                    chart_done_d = 1'b1;
                    state_d      = S_DRAIN;
                end else if (rom_data[15:0] <= frame_q) begin
                    if (free_found) begin
                        valid_d[free_idx] = 1'b1;
                        lane_d[free_idx]  = rom_data[17:16];
                        y_d[free_idx]     = SPAWN_Y;
                    end else begin
                        misses_d = sat8(misses_q);
                        combo_d  = '0;
                    end
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT, S_DRAIN: begin
                if (state_q == S_DRAIN && valid_q == '0) begin
                    state_d = S_IDLE;
                end else if (hit_pend_q) begin
                    hit_pend_d = 1'b0;
                    if (hit_found) begin
                        valid_d[hit_idx] = 1'b0;
                        score_d          = sat16(score_q);
                        combo_d          = sat8(combo_q);
                    end else begin
                        combo_d = '0;
                    end
                end else if (tick || tick_pend_q) begin
                    tick_taken  = 1'b1;
                    tick_pend_d = 1'b0;
                    state_d     = S_MOVE;
                end
            end
            S_MOVE: begin
                frame_d = frame_q + 16'd1;
                for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                    if (valid_q[i]) begin
                        if (int'(y_q[i]) < EXIT_Y || int'(y_q[i]) < SPEED) begin
                            valid_d[i] = 1'b0;
                            misses_d   = sat8(misses_d);
                            combo_d    = '0;
                        end else begin
                            y_d[i] = y_q[i] - STEP;
                        end
                    end
                end
                state_d = chart_done_q ? S_DRAIN : S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

        if (tick && !tick_taken && state_q != S_IDLE) tick_pend_d = 1'b1;

        // A new key event overwrites anything still pending, including one cleared above
        if (press_rise && key_ok) begin
            hit_pend_d = 1'b1;
            hit_lane_d = key_lane;
        end

        if (start) begin
            state_d      = S_FETCH;
            fetch_cnt_d  = 1'b0;
            chart_done_d = 1'b0;
            frame_d      = '0;
            rom_addr_d   = '0;
            tick_pend_d  = 1'b0;
            hit_pend_d   = 1'b0;
            valid_d      = '0;
            lane_d       = '0;
            y_d          = '0;
            score_d      = '0;
            combo_d      = '0;
            misses_d     = '0;
        end
    end

    // State and datapath registers
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            fetch_cnt_q  <= 1'b0;
            chart_done_q <= 1'b0;
            frame_q      <= '0;
            rom_addr_q   <= '0;
            fsync1_q     <= 1'b0;
            fsync2_q     <= 1'b0;
            fsync3_q     <= 1'b0;
            press1_q     <= 1'b0;
            press2_q     <= 1'b0;
            tick_pend_q  <= 1'b0;
            hit_pend_q   <= 1'b0;
            hit_lane_q   <= '0;
            valid_q      <= '0;
            lane_q       <= '0;
            y_q          <= '0;
            score_q      <= '0;
            combo_q      <= '0;
            misses_q     <= '0;
        end else begin
            state_q      <= state_d;
            fetch_cnt_q  <= fetch_cnt_d;
            chart_done_q <= chart_done_d;
            frame_q      <= frame_d;
            rom_addr_q   <= rom_addr_d;
            fsync1_q     <= fsync1_d;
            fsync2_q     <= fsync2_d;
            fsync3_q     <= fsync3_d;
            press1_q     <= press1_d;
            press2_q     <= press2_d;
            tick_pend_q  <= tick_pend_d;
            hit_pend_q   <= hit_pend_d;
            hit_lane_q   <= hit_lane_d;
            valid_q      <= valid_d;
            lane_q       <= lane_d;
            y_q          <= y_d;
            score_q      <= score_d;
            combo_q      <= combo_d;
            misses_q     <= misses_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign note_valid = valid_q;
    assign note_lane  = lane_q;
    assign note_y     = y_q;
    assign score      = score_q;
    assign combo      = combo_q;
    assign misses     = misses_q;
    assign playing    = (state_q != S_IDLE);

endmodule

// File: tb/tb_note_scheduler.sv
// Testbench for note_scheduler: hand-computed vector table, restart/reset
// sequences, and a randomized chart checked against a frame-level model.
`timescale 1ns/1ps
module tb_note_scheduler;
    localparam int NS = 8;
    localparam int OP_START = 0, OP_TICKS = 1, OP_PRESS = 2, OP_STICK = 3;
    localparam logic [18:0] END_E = 19'h40000;

    logic                Clk = 1'b0;
    logic                reset, start, frame_clk, press;
    logic [7:0]          keycode;
    logic [7:0]          rom_addr;
    logic [18:0]         rom_data;
    logic [NS-1:0]       note_valid;
    logic [2*NS-1:0]     note_lane;
    logic [10*NS-1:0]    note_y;
    logic [15:0]         score;
    logic [7:0]          combo, misses;
    logic                playing;
    logic [18:0]         rom_mem [256];
    logic [7:0]          lane_code [4];
    logic [7:0]          any_code [6];
    int                  n_checks = 0;
    int                  n_pass = 0;

    typedef struct {
        int          op;
        int          arg;
        int          ys;
        logic [7:0]  ev;
        logic [9:0]  ey;
        logic [15:0] es;
        logic [7:0]  ec;
        logic [7:0]  em;
        logic        ep;
    } vec_t;
    vec_t vecs [19];

    // Frame-level reference model state
    int m_valid [NS];
    int m_lane [NS];
    int m_y [NS];
    int m_score, m_combo, m_misses, m_frame, m_ptr;
    bit m_done, m_idle;

    note_scheduler #(.NUM_SLOTS(NS), .SPEED(4), .RECEPTOR_Y(64), .WINDOW(12), .ADDR_W(8)) dut (
        .Clk(Clk), .reset(reset), .start(start), .frame_clk(frame_clk),
        .keycode(keycode), .press(press), .rom_addr(rom_addr), .rom_data(rom_data),
        .note_valid(note_valid), .note_lane(note_lane), .note_y(note_y),
        .score(score), .combo(combo), .misses(misses), .playing(playing)
    );

    always #10 Clk = ~Clk;

    always @(posedge Clk) rom_data <= rom_mem[rom_addr];

    initial begin
        #(4_000_000);
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [18:0] ent(input int fr, input int ln);
        return {1'b0, 2'(ln), 16'(fr)};
    endfunction

    task automatic load_chart(input int id);
        for (int i = 0; i < 256; i++) rom_mem[i] = END_E;
        case (id)
            0: rom_mem[0] = ent(2, 0);
            1: begin rom_mem[0] = ent(0, 0); rom_mem[1] = ent(0, 0); end
            2: for (int i = 0; i < 9; i++) rom_mem[i] = ent(0, i % 4);
            3: begin rom_mem[0] = ent(0, 0); rom_mem[1] = ent(0, 1); rom_mem[2] = ent(1, 2); end
            default: ;
        endcase
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            frame_clk = 1'b1; cyc(3);
            frame_clk = 1'b0; cyc(57);
        end
    endtask

    task automatic do_start(input int id);
        load_chart(id);
        start = 1'b1; cyc(1);
        start = 1'b0; cyc(59);
    endtask

    task automatic do_press(input logic [7:0] code);
        keycode = code;
        press = 1'b1; cyc(4);
        press = 1'b0; cyc(6);
    endtask

    function automatic void m_miss();
        m_misses = (m_misses < 255) ? m_misses + 1 : 255;
        m_combo  = 0;
    endfunction

    function automatic void m_settle_idle();
        bit any;
        any = 0;
        for (int i = 0; i < NS; i++) if (m_valid[i] != 0) any = 1;
        if (m_done && !any) m_idle = 1;
    endfunction

    // Spawn every chart entry whose frame has come, in chart order
    function automatic void m_spawn();
        logic [18:0] e;
        int slot;
        while (!m_done) begin
            e = rom_mem[m_ptr];
            if (e[18]) begin m_done = 1; break; end
            if (int'(e[15:0]) > m_frame) break;
            slot = -1;
            for (int i = 0; i < NS; i++) if (m_valid[i] == 0 && slot < 0) slot = i;
            if (slot >= 0) begin
                m_valid[slot] = 1; m_lane[slot] = int'(e[17:16]); m_y[slot] = 479;
            end else m_miss();
            m_ptr++;
        end
        m_settle_idle();
    endfunction

    function automatic void m_start();
        for (int i = 0; i < NS; i++) begin m_valid[i] = 0; m_lane[i] = 0; m_y[i] = 0; end
        m_score = 0; m_combo = 0; m_misses = 0; m_frame = 0; m_ptr = 0;
        m_done = 0; m_idle = 0;
        m_spawn();
    endfunction

    // A note that would end below the window's low edge is a miss
    function automatic void m_tick();
        if (m_idle) return;
        for (int i = 0; i < NS; i++) begin
            if (m_valid[i] != 0) begin
                if (m_y[i] - 4 < 64 - 12) begin m_valid[i] = 0; m_miss(); end
                else m_y[i] = m_y[i] - 4;
            end
        end
        m_frame++;
        m_spawn();
    endfunction

    function automatic void m_press(input logic [7:0] code);
        int ln, best;
        if (m_idle) return;
        ln = -1;
        for (int l = 0; l < 4; l++) if (lane_code[l] == code) ln = l;
        if (ln < 0) return;
        best = -1;
        for (int i = 0; i < NS; i++)
            if (m_valid[i] != 0 && m_lane[i] == ln && m_y[i] >= 52 && m_y[i] <= 76 &&
                (best < 0 || m_y[i] < m_y[best])) best = i;
        if (best >= 0) begin
            m_valid[best] = 0;
            m_score = (m_score < 65535) ? m_score + 1 : 65535;
            m_combo = (m_combo < 255) ? m_combo + 1 : 255;
        end else m_combo = 0;
        m_settle_idle();
    endfunction

    task automatic cmp_model(input int step);
        logic [NS-1:0]    ev;
        logic [2*NS-1:0]  el, al;
        logic [10*NS-1:0] ey, ay;
        for (int i = 0; i < NS; i++) begin
            ev[i]          = (m_valid[i] != 0);
            el[2*i +: 2]   = (m_valid[i] != 0) ? 2'(m_lane[i]) : 2'd0;
            ey[10*i +: 10] = (m_valid[i] != 0) ? 10'(m_y[i]) : 10'd0;
            al[2*i +: 2]   = note_valid[i] ? note_lane[2*i +: 2] : 2'd0;
            ay[10*i +: 10] = note_valid[i] ? note_y[10*i +: 10] : 10'd0;
        end
        chk($sformatf("rand%0d valid", step), 80'(note_valid), 80'(ev));
        chk($sformatf("rand%0d lane", step), 80'(al), 80'(el));
        chk($sformatf("rand%0d y", step), 80'(ay), 80'(ey));
        chk($sformatf("rand%0d score", step), 80'(score), 80'(m_score));
        chk($sformatf("rand%0d combo", step), 80'(combo), 80'(m_combo));
        chk($sformatf("rand%0d misses", step), 80'(misses), 80'(m_misses));
        chk($sformatf("rand%0d playing", step), 80'(playing), 80'(!m_idle));
    endtask

    initial begin
        lane_code = '{8'h6B, 8'h72, 8'h75, 8'h74};
        any_code  = '{8'h6B, 8'h72, 8'h75, 8'h74, 8'h12, 8'h1C};

        // op, arg, slot for y, valid, y, score, combo, misses, playing
        vecs[0]  = '{OP_START, 0,     0, 8'h00, 10'd0,   16'd0, 8'd0, 8'd0, 1'b1};
        vecs[1]  = '{OP_TICKS, 1,     0, 8'h00, 10'd0,   16'd0, 8'd0, 8'd0, 1'b1};
        vecs[2]  = '{OP_TICKS, 1,     0, 8'h01, 10'd479, 16'd0, 8'd0, 8'd0, 1'b1};
        vecs[3]  = '{OP_TICKS, 1,     0, 8'h01, 10'd475, 16'd0, 8'd0, 8'd0, 1'b1};
        vecs[4]  = '{OP_PRESS, 'h74,  0, 8'h01, 10'd475, 16'd0, 8'd0, 8'd0, 1'b1};
        vecs[5]  = '{OP_TICKS, 100,   0, 8'h01, 10'd75,  16'd0, 8'd0, 8'd0, 1'b1};
        vecs[6]  = '{OP_PRESS, 'h74,  0, 8'h01, 10'd75,  16'd0, 8'd0, 8'd0, 1'b1};
        vecs[7]  = '{OP_PRESS, 'h12,  0, 8'h01, 10'd75,  16'd0, 8'd0, 8'd0, 1'b1};
        vecs[8]  = '{OP_TICKS, 3,     0, 8'h01, 10'd63,  16'd0, 8'd0, 8'd0, 1'b1};
        vecs[9]  = '{OP_PRESS, 'h6B,  0, 8'h00, 10'd0,   16'd1, 8'd1, 8'd0, 1'b0};
        vecs[10] = '{OP_TICKS, 1,     0, 8'h00, 10'd0,   16'd1, 8'd1, 8'd0, 1'b0};
        vecs[11] = '{OP_START, 1,     0, 8'h03, 10'd479, 16'd0, 8'd0, 8'd0, 1'b1};
        vecs[12] = '{OP_TICKS, 104,   1, 8'h03, 10'd63,  16'd0, 8'd0, 8'd0, 1'b1};
        vecs[13] = '{OP_PRESS, 'h6B,  1, 8'h02, 10'd63,  16'd1, 8'd1, 8'd0, 1'b1};
        vecs[14] = '{OP_PRESS, 'h74,  1, 8'h02, 10'd63,  16'd1, 8'd0, 8'd0, 1'b1};
        vecs[15] = '{OP_TICKS, 2,     1, 8'h02, 10'd55,  16'd1, 8'd0, 8'd0, 1'b1};
        vecs[16] = '{OP_TICKS, 1,     1, 8'h00, 10'd0,   16'd1, 8'd0, 8'd1, 1'b0};
        vecs[17] = '{OP_START, 2,     7, 8'hFF, 10'd479, 16'd0, 8'd0, 8'd1, 1'b1};
        vecs[18] = '{OP_STICK, 2,     0, 8'hFF, 10'd475, 16'd0, 8'd0, 8'd1, 1'b1};

        reset = 1'b1; start = 1'b0; frame_clk = 1'b0; press = 1'b0; keycode = 8'h00;
        load_chart(0);
        cyc(3);
        chk("reset valid", 80'(note_valid), 80'd0);
        chk("reset score", 80'(score), 80'd0);
        chk("reset combo", 80'(combo), 80'd0);
        chk("reset misses", 80'(misses), 80'd0);
        chk("reset playing", 80'(playing), 80'd0);
        chk("reset rom_addr", 80'(rom_addr), 80'd0);
        reset = 1'b0;
        cyc(2);

        for (int v = 0; v < 19; v++) begin
            case (vecs[v].op)
                OP_START: do_start(vecs[v].arg);
                OP_TICKS: tick(vecs[v].arg);
                OP_PRESS: do_press(8'(vecs[v].arg));
                default: begin
                    load_chart(vecs[v].arg);
                    start = 1'b1; frame_clk = 1'b1; cyc(1);
                    start = 1'b0; cyc(2);
                    frame_clk = 1'b0; cyc(60);
                end
            endcase
            chk($sformatf("vec%0d valid", v), 80'(note_valid), 80'(vecs[v].ev));
            if (vecs[v].ev[vecs[v].ys])
                chk($sformatf("vec%0d y", v), 80'(note_y[10*vecs[v].ys +: 10]), 80'(vecs[v].ey));
            chk($sformatf("vec%0d score", v), 80'(score), 80'(vecs[v].es));
            chk($sformatf("vec%0d combo", v), 80'(combo), 80'(vecs[v].ec));
            chk($sformatf("vec%0d misses", v), 80'(misses), 80'(vecs[v].em));
            chk($sformatf("vec%0d playing", v), 80'(playing), 80'(vecs[v].ep));
        end

        // Restart mid-play: cleared the next cycle, then the chart replays the same way
        do_start(3);
        tick(1);
        chk("pre valid", 80'(note_valid), 80'h07);
        chk("pre lane", 80'(note_lane[5:0]), 80'h24);
        chk("pre y", 80'(note_y[29:0]), 80'({10'd479, 10'd475, 10'd475}));
        tick(1);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("restart valid", 80'(note_valid), 80'd0);
        chk("restart score", 80'(score), 80'd0);
        chk("restart combo", 80'(combo), 80'd0);
        chk("restart misses", 80'(misses), 80'd0);
        chk("restart rom_addr", 80'(rom_addr), 80'd0);
        chk("restart playing", 80'(playing), 80'd1);
        cyc(59);
        tick(1);
        chk("replay valid", 80'(note_valid), 80'h07);
        chk("replay lane", 80'(note_lane[5:0]), 80'h24);
        chk("replay y", 80'(note_y[29:0]), 80'({10'd479, 10'd475, 10'd475}));

        // Reset mid-chart
        tick(1);
        reset = 1'b1; cyc(1); reset = 1'b0;
        chk("midreset valid", 80'(note_valid), 80'd0);
        chk("midreset playing", 80'(playing), 80'd0);
        chk("midreset rom_addr", 80'(rom_addr), 80'd0);
        cyc(2);

        // Randomized chart against the frame-level model
        begin
            int f, step;
            logic [7:0] code;
            load_chart(9);
            f = 0;
            for (int k = 0; k < 16; k++) begin
                f += int'($urandom_range(0, 20));
                rom_mem[k] = ent(f, int'($urandom_range(0, 3)));
            end
            start = 1'b1; cyc(1); start = 1'b0; cyc(59);
            m_start();
            cmp_model(0);
            step = 1;
            while (!m_idle && step < 500) begin
                tick(1);
                m_tick();
                cmp_model(step);
                if ($urandom_range(0, 2) == 0) begin
                    code = any_code[$urandom_range(0, 5)];
                    if ($urandom_range(0, 1) == 1)
                        for (int i = 0; i < NS; i++)
                            if (m_valid[i] != 0 && m_y[i] >= 52 && m_y[i] <= 76) code = lane_code[m_lane[i]];
                    do_press(code);
                    m_press(code);
                    cmp_model(step);
                end
                step++;
            end
            chk("rand final playing", 80'(playing), 80'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
